// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the accumulator CPU: IF -> ID -> execute -> write-back, one state per cycle.
// Latency: outputs are a Moore decode of the state register (plus held Inst); LOAD/R/I = 4 cycles, STORE/JUMP/BEQ = 3.
// No backpressure: the FSM advances every cycle; only init (sync, active-high) or HALT stops it.
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        init,
    input  logic [15:0] Inst,
    output logic        wDataSrc,
    output logic [1:0]  AluSrcA,
    output logic        AluSrcB,
    output logic        memWrite,
    output logic        memRead,
    output logic        PCwrite,
    output logic        PCWriteCond,
    output logic        IRwrite,
    output logic        IorD,
    output logic        regWrite,
    output logic        regWriteALU,
    output logic        move,
    output logic        moveALU,
    output logic [1:0]  PCsrc,
    output logic [2:0]  ALU_opc,
    output logic        halted
);

    localparam logic [3:0] S_IF   = 4'd0;
    localparam logic [3:0] S_ID   = 4'd1;
    localparam logic [3:0] S_LD1  = 4'd2;
    localparam logic [3:0] S_LD2  = 4'd3;
    localparam logic [3:0] S_ST   = 4'd4;
    localparam logic [3:0] S_JMP  = 4'd5;
    localparam logic [3:0] S_BEQ  = 4'd6;
    localparam logic [3:0] S_RX   = 4'd7;
    localparam logic [3:0] S_RW   = 4'd8;
    localparam logic [3:0] S_IX   = 4'd9;
    localparam logic [3:0] S_IW   = 4'd10;
    localparam logic [3:0] S_HALT = 4'd11;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOT   = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic [3:0] opcode;
    logic [2:0] func;

    assign opcode = Inst[15:12];
    assign func   = Inst[2:0];

    // Register/offset fields are consumed by the datapath, not by the controller.
    logic unused_inst_bits;
    assign unused_inst_bits = ^Inst[11:3];

    // State register; init restarts at IF and aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Inst is held by the IR from the end of IF, so ID decodes it directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID: begin
                case (opcode)
                    4'b0000: state_d = S_LD1;
                    4'b0001: state_d = S_ST;
                    4'b0010: state_d = S_JMP;
                    4'b0100: state_d = S_BEQ;
                    4'b1000: state_d = S_RX;
                    4'b1100,
                    4'b1101,
                    4'b1110,
                    4'b1111: state_d = S_IX;
                    4'b0111: state_d = S_HALT;
                    default: state_d = HALT_ON_ILLEGAL ? S_HALT : S_IF;
                endcase
            end
            S_LD1:  state_d = S_LD2;
            S_LD2:  state_d = S_IF;
            S_ST:   state_d = S_IF;
            S_JMP:  state_d = S_IF;
            S_BEQ:  state_d = S_IF;
            S_RX:   state_d = S_RW;
            S_RW:   state_d = S_IF;
            S_IX:   state_d = S_IW;
            S_IW:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            // Unused encodings park safely rather than issuing strobes.
            default: state_d = S_HALT;
        endcase
    end

    // Moore output decode; init gates every output low, including halted.
    always_comb begin
        wDataSrc    = 1'b0;
        AluSrcA     = 2'd0;
        AluSrcB     = 1'b0;
        memWrite    = 1'b0;
        memRead     = 1'b0;
        PCwrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRwrite     = 1'b0;
        IorD        = 1'b0;
        regWrite    = 1'b0;
        regWriteALU = 1'b0;
        move        = 1'b0;
        moveALU     = 1'b0;
        PCsrc       = 2'd0;
        ALU_opc     = OP_ADD;
        halted      = 1'b0;
        if (!init) begin
            case (state_q)
                S_IF: begin
                    // Fetch and PC+1 share the cycle: ALU adds {4'b0,PC} + 1.
                    memRead = 1'b1;
                    IRwrite = 1'b1;
                    AluSrcA = 2'd1;
                    AluSrcB = 1'b1;
                    ALU_opc = OP_ADD;
                    PCsrc   = 2'd0;
                    PCwrite = 1'b1;
                end
                S_LD1: begin
                    memRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_LD2: begin
                    wDataSrc    = 1'b0;
                    regWrite    = 1'b1;
                    regWriteALU = 1'b1;
                end
                S_ST: begin
                    memWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_JMP: begin
                    PCsrc   = 2'd2;
                    PCwrite = 1'b1;
                end
                S_BEQ: begin
                    // Ri - R0; Zero qualifies the page-relative branch.
                    AluSrcA     = 2'd2;
                    AluSrcB     = 1'b0;
                    ALU_opc     = OP_SUB;
                    PCsrc       = 2'd1;
                    PCWriteCond = 1'b1;
                end
                S_RX: begin
                    AluSrcA = 2'd2;
                    AluSrcB = 1'b0;
                    case (func)
                        3'b000:  ALU_opc = OP_PASSB;  // MOVETO: Ri <- R0
                        3'b001:  ALU_opc = OP_PASSA;  // MOVEFROM: R0 <- Ri
                        3'b010:  ALU_opc = OP_ADD;
                        3'b011:  ALU_opc = OP_SUB;
                        3'b100:  ALU_opc = OP_AND;
                        3'b101:  ALU_opc = OP_OR;
                        3'b110:  ALU_opc = OP_NOT;
                        default: ALU_opc = OP_ADD;    // NOP: result is discarded
                    endcase
                end
                S_RW: begin
                    wDataSrc    = 1'b1;
                    regWrite    = 1'b1;
                    move        = 1'b1;
                    regWriteALU = (func != 3'b111);
                    moveALU     = (func == 3'b000);
                end
                S_IX: begin
                    // Opcodes 1100..1111 map in order onto ADD/SUB/AND/OR.
                    AluSrcA = 2'd0;
                    AluSrcB = 1'b0;
                    ALU_opc = {1'b0, opcode[1:0]};
                end
                S_IW: begin
                    wDataSrc    = 1'b1;
                    regWrite    = 1'b1;
                    regWriteALU = 1'b1;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: per-cycle expected output words, hand-computed.
// Latency: outputs are sampled #1 after each rising edge (or #1 after an init change).
// No backpressure involved; every wait is a fixed cycle count, so the run always terminates.
module tb_multicycle_controller;

    logic        clk;
    logic        init;
    logic [15:0] Inst;

    logic        wDataSrc, AluSrcB, memWrite, memRead, PCwrite, PCWriteCond, IRwrite, IorD;
    logic        regWrite, regWriteALU, move, moveALU, halted;
    logic [1:0]  AluSrcA, PCsrc;
    logic [2:0]  ALU_opc;

    logic        n_wDataSrc, n_AluSrcB, n_memWrite, n_memRead, n_PCwrite, n_PCWriteCond, n_IRwrite, n_IorD;
    logic        n_regWrite, n_regWriteALU, n_move, n_moveALU, n_halted;
    logic [1:0]  n_AluSrcA, n_PCsrc;
    logic [2:0]  n_ALU_opc;

    int nvec  = 0;
    int nfail = 0;

    // Packed view of every output: bit19 wDataSrc ... bit0 halted.
    logic [19:0] obs, obs2;
    assign obs  = {wDataSrc, AluSrcA, AluSrcB, memWrite, memRead, PCwrite, PCWriteCond, IRwrite, IorD,
                   regWrite, regWriteALU, move, moveALU, PCsrc, ALU_opc, halted};
    assign obs2 = {n_wDataSrc, n_AluSrcA, n_AluSrcB, n_memWrite, n_memRead, n_PCwrite, n_PCWriteCond,
                   n_IRwrite, n_IorD, n_regWrite, n_regWriteALU, n_move, n_moveALU, n_PCsrc, n_ALU_opc, n_halted};

    localparam logic [19:0] HLT  = 20'h00001;
    localparam logic [19:0] PCS1 = 20'h00010;
    localparam logic [19:0] PCS2 = 20'h00020;
    localparam logic [19:0] MVA  = 20'h00040;
    localparam logic [19:0] MV   = 20'h00080;
    localparam logic [19:0] RWA  = 20'h00100;
    localparam logic [19:0] RW   = 20'h00200;
    localparam logic [19:0] IORD = 20'h00400;
    localparam logic [19:0] IRW  = 20'h00800;
    localparam logic [19:0] PCWC = 20'h01000;
    localparam logic [19:0] PCW  = 20'h02000;
    localparam logic [19:0] MR   = 20'h04000;
    localparam logic [19:0] MW   = 20'h08000;
    localparam logic [19:0] ASB  = 20'h10000;
    localparam logic [19:0] ASA1 = 20'h20000;
    localparam logic [19:0] ASA2 = 20'h40000;
    localparam logic [19:0] WDS  = 20'h80000;
    localparam logic [19:0] OPMASK = 20'h0000E;

    function automatic logic [19:0] opf(input logic [2:0] v);
        return {16'd0, v, 1'b0};
    endfunction

    localparam logic [19:0] ZERO = 20'h00000;
    localparam logic [19:0] E_IF = ASA1 | ASB | MR | IRW | PCW;
    localparam logic [19:0] E_ID = ZERO;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .init(init), .Inst(Inst),
        .wDataSrc(wDataSrc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .memWrite(memWrite), .memRead(memRead),
        .PCwrite(PCwrite), .PCWriteCond(PCWriteCond), .IRwrite(IRwrite), .IorD(IorD), .regWrite(regWrite),
        .regWriteALU(regWriteALU), .move(move), .moveALU(moveALU), .PCsrc(PCsrc), .ALU_opc(ALU_opc),
        .halted(halted)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .init(init), .Inst(Inst),
        .wDataSrc(n_wDataSrc), .AluSrcA(n_AluSrcA), .AluSrcB(n_AluSrcB), .memWrite(n_memWrite),
        .memRead(n_memRead), .PCwrite(n_PCwrite), .PCWriteCond(n_PCWriteCond), .IRwrite(n_IRwrite),
        .IorD(n_IorD), .regWrite(n_regWrite), .regWriteALU(n_regWriteALU), .move(n_move),
        .moveALU(n_moveALU), .PCsrc(n_PCsrc), .ALU_opc(n_ALU_opc), .halted(n_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        init = 1'b1;
        Inst = 16'hxxxx;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            nvec++;
            if (obs !== ZERO) begin
                nfail++;
                $display("FAIL reset_hold c%0d got %h want %h", c, obs, ZERO);
            end
        end
        init = 1'b0;
        #1;
        nvec++;
        if (obs !== E_IF) begin
            nfail++;
            $display("FAIL reset_release_if got %h want %h", obs, E_IF);
        end
    endtask

    task automatic test_load();
        logic [19:0] ev [5];
        ev = '{E_IF, E_ID, MR | IORD, RW | RWA, E_IF};
        Inst = 16'h0123;
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); #1;
            nvec++;
            if (obs !== ev[c]) begin
                nfail++;
                $display("FAIL load c%0d got %h want %h", c, obs, ev[c]);
            end
        end
    endtask

    task automatic test_store_jump();
        logic [19:0] ev [2][4];
        logic [15:0] ins [2];
        ins   = '{16'h1055, 16'h2ABC};
        ev[0] = '{E_IF, E_ID, MW | IORD, E_IF};
        ev[1] = '{E_IF, E_ID, PCS2 | PCW, E_IF};
        for (int k = 0; k < 2; k++) begin
            Inst = ins[k];
            for (int c = 1; c < 4; c++) begin
                @(posedge clk); #1;
                nvec++;
                if (obs !== ev[k][c]) begin
                    nfail++;
                    $display("FAIL st_jmp inst %h c%0d got %h want %h", ins[k], c, obs, ev[k][c]);
                end
            end
        end
    endtask

    task automatic test_beq();
        logic [19:0] ev [4];
        ev = '{E_IF, E_ID, ASA2 | opf(3'b001) | PCS1 | PCWC, E_IF};
        Inst = 16'h4A05;
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1;
            nvec++;
            if (obs !== ev[c]) begin
                nfail++;
                $display("FAIL beq c%0d got %h want %h", c, obs, ev[c]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [19:0] ev [4][5];
        logic [19:0] mk [4][5];
        logic [15:0] ins [4];
        ins   = '{16'h8600, 16'h8207, 16'h8202, 16'h8A06};
        ev[0] = '{E_IF, E_ID, ASA2 | opf(3'b110), WDS | RW | RWA | MV | MVA, E_IF};
        ev[1] = '{E_IF, E_ID, ASA2,               WDS | RW | MV,             E_IF};
        ev[2] = '{E_IF, E_ID, ASA2 | opf(3'b000), WDS | RW | RWA | MV,       E_IF};
        ev[3] = '{E_IF, E_ID, ASA2 | opf(3'b100), WDS | RW | RWA | MV,       E_IF};
        for (int k = 0; k < 4; k++) mk[k] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
        // NOP's ALU operation is a don't-care in the execute cycle.
        mk[1][2] = ~OPMASK;
        for (int k = 0; k < 4; k++) begin
            Inst = ins[k];
            for (int c = 1; c < 5; c++) begin
                @(posedge clk); #1;
                nvec++;
                if ((obs & mk[k][c]) !== (ev[k][c] & mk[k][c])) begin
                    nfail++;
                    $display("FAIL rtype inst %h c%0d got %h want %h", ins[k], c, obs, ev[k][c]);
                end
            end
        end
    endtask

    task automatic test_immediate();
        logic [15:0] ins [4];
        logic [19:0] ev [5];
        ins = '{16'hC005, 16'hD001, 16'hE0F0, 16'hF00F};
        for (int k = 0; k < 4; k++) begin
            ev = '{E_IF, E_ID, opf(3'(k)), WDS | RW | RWA, E_IF};
            Inst = ins[k];
            for (int c = 1; c < 5; c++) begin
                @(posedge clk); #1;
                nvec++;
                if (obs !== ev[c]) begin
                    nfail++;
                    $display("FAIL imm inst %h c%0d got %h want %h", ins[k], c, obs, ev[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_instruction();
        Inst = 16'h0123;
        @(posedge clk); #1;   // ID
        @(posedge clk); #1;   // LD1
        nvec++;
        if (obs !== (MR | IORD)) begin
            nfail++;
            $display("FAIL midrst_ld1 got %h want %h", obs, MR | IORD);
        end
        init = 1'b1;
        #1;
        nvec++;
        if (obs !== ZERO) begin
            nfail++;
            $display("FAIL midrst_gated got %h want %h", obs, ZERO);
        end
        @(posedge clk); #1;
        nvec++;
        if (regWrite !== 1'b0) begin
            nfail++;
            $display("FAIL midrst_no_ld2 regWrite got %b want 0", regWrite);
        end
        init = 1'b0;
        #1;
        nvec++;
        if (obs !== E_IF) begin
            nfail++;
            $display("FAIL midrst_restart_if got %h want %h", obs, E_IF);
        end
        Inst = 16'h1055;
        @(posedge clk); #1;
        nvec++;
        if (obs !== E_ID) begin
            nfail++;
            $display("FAIL midrst_then_id got %h want %h", obs, E_ID);
        end
        @(posedge clk); #1;   // ST
        @(posedge clk); #1;   // IF
        nvec++;
        if (obs !== E_IF) begin
            nfail++;
            $display("FAIL midrst_st_back_if got %h want %h", obs, E_IF);
        end
    endtask

    task automatic test_illegal_halt();
        Inst = 16'h3000;
        @(posedge clk); #1;   // ID
        nvec++;
        if (obs !== E_ID) begin
            nfail++;
            $display("FAIL illegal_id got %h want %h", obs, E_ID);
        end
        @(posedge clk); #1;
        nvec++;
        if (obs2 !== E_IF) begin
            nfail++;
            $display("FAIL illegal_as_nop got %h want %h", obs2, E_IF);
        end
        nvec++;
        if (obs !== HLT) begin
            nfail++;
            $display("FAIL halt_enter got %h want %h", obs, HLT);
        end
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            nvec++;
            if (obs !== HLT) begin
                nfail++;
                $display("FAIL halt_hold c%0d got %h want %h", c, obs, HLT);
            end
        end
        init = 1'b1;
        #1;
        nvec++;
        if (obs !== ZERO) begin
            nfail++;
            $display("FAIL halt_init_gated got %h want %h", obs, ZERO);
        end
        @(posedge clk); #1;
        init = 1'b0;
        #1;
        nvec++;
        if (obs !== E_IF) begin
            nfail++;
            $display("FAIL halt_exit_if got %h want %h", obs, E_IF);
        end
    endtask

    task automatic test_explicit_halt();
        Inst = 16'h7000;
        @(posedge clk); #1;   // ID
        @(posedge clk); #1;
        nvec++;
        if (obs !== HLT) begin
            nfail++;
            $display("FAIL halt_opcode got %h want %h", obs, HLT);
        end
        nvec++;
        if (obs2 !== HLT) begin
            nfail++;
            $display("FAIL halt_opcode_nopvariant got %h want %h", obs2, HLT);
        end
    endtask

    initial begin
        init = 1'b1;
        Inst = 16'h0000;
        test_reset();
        test_load();
        test_store_jump();
        test_beq();
        test_rtype();
        test_immediate();
        test_reset_mid_instruction();
        test_illegal_halt();
        test_explicit_halt();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
